// File: rtl/pgm_prefetch_buffer.sv
// Instruction prefetch queue between the program memory bus and the IF stage.
// Issues sequential word fetches ahead of consumption. Memory requests are credit
// limited, so every response is guaranteed a free queue slot. A redirect flushes the
// queue and marks all in-flight responses for discard.
module pgm_prefetch_buffer #(
   parameter int unsigned         PC_WIDTH  = 32,
   parameter int unsigned         DEPTH     = 4,
   parameter int unsigned         MAX_OUTST = 2,
   parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
   input  logic                i_Clock,
   input  logic                i_Reset,
   input  logic                i_Redirect,
   input  logic [PC_WIDTH-1:0] i_RedirectPC,
   output logic                o_MemReq,
   output logic [PC_WIDTH-1:0] o_MemAddr,
   input  logic                i_MemAck,
   input  logic                i_MemRdValid,
   input  logic [31:0]         i_MemRdData,
   output logic                o_InstValid,
   output logic [31:0]         o_Inst,
   output logic [PC_WIDTH-1:0] o_InstPC,
   input  logic                i_InstReady
);

   localparam int unsigned ptrWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned cntWidth = $clog2(DEPTH + 1);
   localparam int unsigned outWidth = $clog2(MAX_OUTST + 1);
   localparam logic [PC_WIDTH-1:0] pcStep = PC_WIDTH'(4);

   // Registered state
   logic                running;
   logic [cntWidth-1:0] count;
   logic [outWidth-1:0] outst;
   logic [outWidth-1:0] discard;
   logic [PC_WIDTH-1:0] fetchPC;
   logic [PC_WIDTH-1:0] respPC;
   logic [ptrWidth-1:0] rdPtr;
   logic [ptrWidth-1:0] wrPtr;
   logic [31:0]         headInst;
   logic [PC_WIDTH-1:0] headPC;

   // Queue storage (no reset needed: only read behind a valid count)
   logic [31:0]         memData [DEPTH];
   logic [PC_WIDTH-1:0] memPC   [DEPTH];

   // Next-state signals
   logic                accept;
   logic                rspValid;
   logic                dropRsp;
   logic                push;
   logic                pop;
   logic [cntWidth-1:0] countNext;
   logic [outWidth-1:0] outstNext;
   logic [outWidth-1:0] discardNext;
   logic [PC_WIDTH-1:0] fetchPCNext;
   logic [PC_WIDTH-1:0] respPCNext;
   logic [ptrWidth-1:0] rdPtrNext;
   logic [ptrWidth-1:0] wrPtrNext;
   logic [31:0]         headInstNext;
   logic [PC_WIDTH-1:0] headPCNext;

   // Credit check: only request when both a memory slot and a queue slot are reserved
   assign o_MemReq    = running && (int'(outst) < int'(MAX_OUTST)) &&
                        ((int'(outst) + int'(count)) < int'(DEPTH));
   assign o_MemAddr   = fetchPC;
   assign o_InstValid = (count != '0);
   assign o_Inst      = headInst;
   assign o_InstPC    = headPC;

   // Next-state computation for counters, pointers, PCs and head registers
   always_comb begin
      accept    = o_MemReq && i_MemAck;
      rspValid  = i_MemRdValid && (outst != '0);
      dropRsp   = rspValid && (discard != '0);
      push      = rspValid && !dropRsp && !i_Redirect;
      pop       = o_InstValid && i_InstReady && !i_Redirect;
      outstNext = outst + outWidth'(accept) - outWidth'(rspValid);

      if (i_Redirect) begin
         // Everything still in flight, including a same-cycle accept, is stale
         countNext   = '0;
         rdPtrNext   = '0;
         wrPtrNext   = '0;
         discardNext = outstNext;
         fetchPCNext = i_RedirectPC;
         respPCNext  = i_RedirectPC;
      end else begin
         countNext   = count + cntWidth'(push) - cntWidth'(pop);
         rdPtrNext   = pop ? rdPtr + ptrWidth'(1) : rdPtr;
         wrPtrNext   = push ? wrPtr + ptrWidth'(1) : wrPtr;
         discardNext = dropRsp ? discard - outWidth'(1) : discard;
         fetchPCNext = accept ? fetchPC + pcStep : fetchPC;
         respPCNext  = push ? respPC + pcStep : respPC;
      end

      // Head registers hold their last value while the queue is empty
      headInstNext = headInst;
      headPCNext   = headPC;
      if (countNext != '0) begin
         if (push && (count == cntWidth'(pop))) begin
            // Queue drains to zero this cycle, so the pushed word becomes the head
            headInstNext = i_MemRdData;
            headPCNext   = respPC;
         end else begin
            headInstNext = memData[rdPtrNext];
            headPCNext   = memPC[rdPtrNext];
         end
      end
   end

   // Control and head state with asynchronous active-low reset
   always_ff @(posedge i_Clock or negedge i_Reset) begin
      if (!i_Reset) begin
         running  <= 1'b0;
         count    <= '0;
         outst    <= '0;
         discard  <= '0;
         fetchPC  <= RESET_PC;
         respPC   <= RESET_PC;
         rdPtr    <= '0;
         wrPtr    <= '0;
         headInst <= '0;
         headPC   <= RESET_PC;
      end else begin
         running  <= 1'b1;
         count    <= countNext;
         outst    <= outstNext;
         discard  <= discardNext;
         fetchPC  <= fetchPCNext;
         respPC   <= respPCNext;
         rdPtr    <= rdPtrNext;
         wrPtr    <= wrPtrNext;
         headInst <= headInstNext;
         headPC   <= headPCNext;
      end
   end

   // Queue storage write on accepted response
   always_ff @(posedge i_Clock) begin
      if (push) begin
         memData[wrPtr] <= i_MemRdData;
         memPC[wrPtr]   <= respPC;
      end
   end

   // Bus protocol and occupancy invariants
   assert property (@(posedge i_Clock) disable iff (!i_Reset)
                    i_MemRdValid |-> (outst != '0));
   assert property (@(posedge i_Clock) disable iff (!i_Reset)
                    discard <= outst);
   assert property (@(posedge i_Clock) disable iff (!i_Reset)
                    (int'(count) + int'(outst)) <= int'(DEPTH));

endmodule

// File: tb/tb_pgm_prefetch_buffer.sv
// Scoreboard bench for pgm_prefetch_buffer: a bench memory model answers fetches,
// directed phases push expected {PC, word} pairs, a monitor compares every pop.
module tb_pgm_prefetch_buffer;

   logic        clk = 1'b0;
   logic        rstN;
   logic        redirect;
   logic [31:0] redirectPC;
   logic        memReq;
   logic [31:0] memAddr;
   logic        memAck;
   logic        memRdValid;
   logic [31:0] memRdData;
   logic        instValid;
   logic [31:0] inst;
   logic [31:0] instPC;
   logic        instReady;

   always #5 clk = ~clk;

   pgm_prefetch_buffer dut (
      .i_Clock      (clk),
      .i_Reset      (rstN),
      .i_Redirect   (redirect),
      .i_RedirectPC (redirectPC),
      .o_MemReq     (memReq),
      .o_MemAddr    (memAddr),
      .i_MemAck     (memAck),
      .i_MemRdValid (memRdValid),
      .i_MemRdData  (memRdData),
      .o_InstValid  (instValid),
      .o_Inst       (inst),
      .o_InstPC     (instPC),
      .i_InstReady  (instReady)
   );

   int          checks = 0;
   int          passes = 0;
   int          pops = 0;
   logic [63:0] expQ[$];
   logic [31:0] respAddr[$];
   int          respDue[$];
   int          cyc = 0;
   int          memLat = 1;
   bit          ackEnable = 1'b1;
   int          stallLeft = 0;
   bit          stallActive = 1'b0;
   int          stallSeen = 0;
   logic [31:0] stallAddr = 32'h8;

   function automatic logic [31:0] memWord(input logic [31:0] a);
      return {a[15:0] ^ 16'hBEEF, a[15:0] ^ 16'h1234};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h, wanted %h", name, act, exp);
   endtask

   task automatic expectFrom(input logic [31:0] pc, input int n);
      for (int i = 0; i < n; i++) begin
         logic [31:0] a;
         a = pc + 32'(4 * i);
         expQ.push_back({a, memWord(a)});
      end
   endtask

   // One clock cycle: advance to negedge and drive the memory side
   task automatic cycle();
      @(negedge clk);
      cyc++;
      redirect   = 1'b0;
      memAck     = 1'b0;
      memRdValid = 1'b0;
      memRdData  = '0;
      if (respAddr.size() != 0 && respDue[0] <= cyc) begin
         memRdValid = 1'b1;
         memRdData  = memWord(respAddr.pop_front());
         void'(respDue.pop_front());
      end
      if (stallActive || (memReq && stallLeft > 0 && memAddr == stallAddr)) begin
         if (stallActive)
            check("stall_hold", {31'b0, memReq, memAddr}, {32'd1, stallAddr});
         stallActive = (stallLeft > 1);
         stallLeft--;
         stallSeen++;
      end else if (memReq && ackEnable) begin
         memAck = 1'b1;
         respAddr.push_back(memAddr);
         respDue.push_back(cyc + memLat);
      end
   endtask

   task automatic checkResetOutputs();
      check("rst_memreq", 64'(memReq), 64'd0);
      check("rst_memaddr", 64'(memAddr), 64'd0);
      check("rst_valid", 64'(instValid), 64'd0);
      check("rst_inst", 64'(inst), 64'd0);
      check("rst_instpc", 64'(instPC), 64'd0);
   endtask

   task automatic applyReset();
      cycle();
      #1 rstN = 1'b0;
      respAddr.delete();
      respDue.delete();
      expQ.delete();
      memRdValid = 1'b0;
      memAck     = 1'b0;
      #1 checkResetOutputs();
   endtask

   // Release reset and measure edges until the first word is presented
   task automatic releaseAndFill();
      int n;
      expQ.delete();
      expectFrom(32'h0, 64);
      cycle();
      rstN      = 1'b1;
      instReady = 1'b1;
      check("run_gate", 64'(memReq), 64'd0);
      n = 0;
      while (n < 10 && !instValid) begin
         cycle();
         n++;
      end
      check("fill_latency", 64'(n), 64'd3);
   endtask

   task automatic redirectTo(input logic [31:0] pc);
      redirect   = 1'b1;
      redirectPC = pc;
      expQ.delete();
      expectFrom(pc, 64);
      cycle();
      check("flush_valid", 64'(instValid), 64'd0);
   endtask

   task automatic findTwoInFlight();
      bit found;
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         cycle();
         if (respAddr.size() == 2 && !memAck && !memRdValid) found = 1'b1;
      end
      check("two_in_flight", 64'(found), 64'd1);
   endtask

   task automatic runAndExpectPops(input string name, input int n);
      int p0;
      p0 = pops;
      repeat (n) cycle();
      check(name, 64'(pops > p0), 64'd1);
   endtask

   // Monitor: compare every handshake against the scoreboard head
   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (rstN && !redirect && instValid && instReady) begin
            pops++;
            if (expQ.size() == 0) begin
               checks++;
               $display("FAIL pop_unexpected: got pc %h, wanted no word", instPC);
            end else begin
               check("pop_word", {instPC, inst}, expQ.pop_front());
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int v;
      int n;
      bit hit;
      rstN       = 1'b0;
      redirect   = 1'b0;
      redirectPC = '0;
      memAck     = 1'b0;
      memRdValid = 1'b0;
      memRdData  = '0;
      instReady  = 1'b0;
      #1 checkResetOutputs();
      cycle();

      // Zero-wait stream: one word per cycle after fill
      releaseAndFill();
      v = 0;
      repeat (16) begin
         if (instValid) v++;
         cycle();
      end
      check("stream_rate", 64'(v), 64'd16);

      // Back-pressure: queue fills to DEPTH and requests stop
      instReady = 1'b0;
      repeat (10) cycle();
      check("full_memreq", 64'(memReq), 64'd0);
      check("full_valid", 64'(instValid), 64'd1);
      ackEnable = 1'b0;
      instReady = 1'b1;
      n = 0;
      for (int k = 0; k < 10; k++) begin
         if (!instValid) break;
         n++;
         cycle();
      end
      check("full_count", 64'(n), 64'd4);
      ackEnable = 1'b1;
      runAndExpectPops("resume_after_full", 8);

      // Ack stall at 0x8
      applyReset();
      stallLeft = 3;
      releaseAndFill();
      runAndExpectPops("stall_stream", 12);
      check("stall_cycles", 64'(stallSeen), 64'd3);

      // Redirect with two requests in flight
      memLat = 3;
      findTwoInFlight();
      redirectTo(32'h100);
      runAndExpectPops("redirect_100", 16);

      // Redirect in the same cycle as an ack and a response
      memLat = 1;
      hit = 1'b0;
      for (int k = 0; k < 20 && !hit; k++) begin
         cycle();
         if (memAck && memRdValid) hit = 1'b1;
      end
      check("ack_rd_cycle", 64'(hit), 64'd1);
      redirectTo(32'h200);
      runAndExpectPops("redirect_200", 12);

      // Back-to-back redirects while discards are pending
      memLat = 3;
      findTwoInFlight();
      redirectTo(32'h300);
      redirectTo(32'h400);
      runAndExpectPops("redirect_400", 16);

      // Reset with words queued and requests outstanding
      instReady = 1'b0;
      memLat    = 2;
      hit = 1'b0;
      for (int k = 0; k < 20 && !hit; k++) begin
         cycle();
         if (instValid && respAddr.size() != 0) hit = 1'b1;
      end
      check("busy_before_reset", 64'(hit), 64'd1);
      applyReset();
      memLat = 1;
      releaseAndFill();
      runAndExpectPops("restart_stream", 8);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
